// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file write-back path.
package regfile_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 64;
   localparam logic [REG_AW-1:0] XZR_IDX = 5'd31;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] reg_idx;
      logic [REG_DW-1:0] data;
   } wbq_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_forward.sv
// Newest-match search over queued write-backs for one read port.
// Walks oldest to newest from head so the last hit found wins.
module wbq_forward_match
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH)
) (
   input  wbq_entry_t        entries [DEPTH],
   input  logic [PW-1:0]     head,
   input  logic [REG_AW-1:0] rd_reg,
   output logic              hit,
   output logic [REG_DW-1:0] data
);

   logic [PW-1:0] idx;

   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (entries[idx].valid && entries[idx].reg_idx == rd_reg) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-back FIFO in front of the register file write port, with read forwarding.
// Optional same-cycle enqueue bypass: define REGFILE_WBQ_ENQ_BYPASS_EN.
module regfile_writeback_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = REG_DW,
   parameter int AW    = REG_AW
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wb_valid,
   output logic                         wb_ready,
   input  logic [AW-1:0]                wb_reg,
   input  logic [DW-1:0]                wb_data,
   input  logic                         drain_en,
   output logic                         RegWrite,
   output logic [AW-1:0]                WriteRegister,
   output logic [DW-1:0]                WriteData,
   input  logic [AW-1:0]                ReadRegister1,
   input  logic [AW-1:0]                ReadRegister2,
   input  logic [DW-1:0]                RfData1,
   input  logic [DW-1:0]                RfData2,
   output logic [DW-1:0]                ReadData1,
   output logic [DW-1:0]                ReadData2,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   wbq_entry_t    entries [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] cnt;

   logic enq;
   logic store;
   logic deq;

   assign empty    = (cnt == '0);
   assign wb_ready = (cnt != FULL);
   assign count    = cnt;

   assign enq   = wb_valid && wb_ready;
   assign store = enq && (wb_reg != XZR_IDX);
   assign deq   = !empty && drain_en;

   assign RegWrite      = deq;
   assign WriteRegister = empty ? '0 : entries[head].reg_idx;
   assign WriteData     = empty ? '0 : entries[head].data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         if (deq) begin
            entries[head].valid <= 1'b0;
            head <= head + 1'b1;
         end
         // store into the tail cannot alias the draining head:
         // that would need count 0 (no deq) or count DEPTH (no store)
         if (store) begin
            entries[tail] <= '{valid: 1'b1, reg_idx: wb_reg, data: wb_data};
            tail <= tail + 1'b1;
         end
         unique case ({store, deq})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   logic          hit1;
   logic          hit2;
   logic [DW-1:0] fdata1;
   logic [DW-1:0] fdata2;

   wbq_forward_match #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_match1 (
      .entries (entries),
      .head    (head),
      .rd_reg  (ReadRegister1),
      .hit     (hit1),
      .data    (fdata1)
   );

   wbq_forward_match #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_match2 (
      .entries (entries),
      .head    (head),
      .rd_reg  (ReadRegister2),
      .hit     (hit2),
      .data    (fdata2)
   );

   always_comb begin
      ReadData1 = RfData1;
      if (ReadRegister1 == XZR_IDX) begin
         ReadData1 = '0;
`ifdef REGFILE_WBQ_ENQ_BYPASS_EN
      end else if (store && wb_reg == ReadRegister1) begin
         ReadData1 = wb_data;
`endif
      end else if (hit1) begin
         ReadData1 = fdata1;
      end
   end

   always_comb begin
      ReadData2 = RfData2;
      if (ReadRegister2 == XZR_IDX) begin
         ReadData2 = '0;
`ifdef REGFILE_WBQ_ENQ_BYPASS_EN
      end else if (store && wb_reg == ReadRegister2) begin
         ReadData2 = wb_data;
`endif
      end else if (hit2) begin
         ReadData2 = fdata2;
      end
   end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue (DEPTH=4).
module tb_regfile_writeback_queue;

   logic        clk;
   logic        reset;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_reg;
   logic [63:0] wb_data;
   logic        drain_en;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [63:0] RfData1;
   logic [63:0] RfData2;
   logic [63:0] ReadData1;
   logic [63:0] ReadData2;
   logic [2:0]  count;
   logic        empty;

   int checks = 0;
   int errors = 0;

   regfile_writeback_queue #(.DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_reg        (wb_reg),
      .wb_data       (wb_data),
      .drain_en      (drain_en),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .RfData1       (RfData1),
      .RfData2       (RfData2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .count         (count),
      .empty         (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // inputs change at negedge; outputs sampled 1ns later, far from posedge
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      wb_valid = 1'b0;
      wb_reg = '0;
      wb_data = '0;
      drain_en = 1'b1;
      ReadRegister1 = '0;
      ReadRegister2 = '0;
      RfData1 = '0;
      RfData2 = '0;

      step();
      check("rst_count", 64'(count), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_ready", 64'(wb_ready), 64'd1);
      check("rst_regwrite", 64'(RegWrite), 64'd0);
      check("rst_wreg", 64'(WriteRegister), 64'd0);
      check("rst_wdata", WriteData, 64'd0);

      // reset mid-drain
      @(negedge clk);
      reset = 1'b1;
      drain_en = 1'b0;
      wb_valid = 1'b1;
      wb_reg = 5'd3;
      wb_data = 64'hAA;
      @(negedge clk);
      wb_reg = 5'd4;
      wb_data = 64'hBB;
      @(negedge clk);
      wb_valid = 1'b0;
      drain_en = 1'b1;
      #1;
      check("md_count2", 64'(count), 64'd2);
      check("md_regwrite", 64'(RegWrite), 64'd1);
      check("md_wreg3", 64'(WriteRegister), 64'd3);
      check("md_wdata3", WriteData, 64'hAA);
      #1;
      reset = 1'b0;
      #1;
      check("md_rst_rw", 64'(RegWrite), 64'd0);
      check("md_rst_count", 64'(count), 64'd0);
      check("md_rst_empty", 64'(empty), 64'd1);
      check("md_rst_ready", 64'(wb_ready), 64'd1);
      step();
      check("md_hold_rw", 64'(RegWrite), 64'd0);
      check("md_hold_cnt", 64'(count), 64'd0);
      reset = 1'b1;
      step();
      check("md_no_x4", 64'(RegWrite), 64'd0);
      check("md_no_x4_e", 64'(empty), 64'd1);

      // basic latency, no pass-through
      @(negedge clk);
      wb_valid = 1'b1;
      wb_reg = 5'd5;
      wb_data = 64'h1234;
      #1;
      check("lat_no_pass", 64'(RegWrite), 64'd0);
      @(negedge clk);
      wb_valid = 1'b0;
      #1;
      check("lat_rw", 64'(RegWrite), 64'd1);
      check("lat_wreg", 64'(WriteRegister), 64'd5);
      check("lat_wdata", WriteData, 64'h1234);
      step();
      check("lat_empty", 64'(empty), 64'd1);

      // fill to full with drain held off
      drain_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         wb_valid = 1'b1;
         wb_reg = 5'(i);
         wb_data = 64'(i * 16'h11);
      end
      @(negedge clk);
      wb_reg = 5'd9;
      wb_data = 64'h99;
      #1;
      check("full_count", 64'(count), 64'd4);
      check("full_ready", 64'(wb_ready), 64'd0);
      @(negedge clk);
      wb_valid = 1'b0;
      drain_en = 1'b1;
      #1;
      check("full_5th", 64'(count), 64'd4);
      check("full_ready_d", 64'(wb_ready), 64'd0);
      for (int i = 1; i <= 4; i++) begin
         check("full_rw", 64'(RegWrite), 64'd1);
         check("full_wreg", 64'(WriteRegister), 64'(i));
         check("full_wdata", WriteData, 64'(i * 16'h11));
         step();
         check("full_ready_a", 64'(wb_ready), 64'd1);
      end
      check("full_empty", 64'(empty), 64'd1);

      // XZR writes dropped, XZR reads zero
      @(negedge clk);
      wb_valid = 1'b1;
      wb_reg = 5'd31;
      wb_data = 64'hFFFF;
      ReadRegister1 = 5'd31;
      RfData1 = 64'h55;
      #1;
      check("xzr_ready", 64'(wb_ready), 64'd1);
      check("xzr_read", ReadData1, 64'd0);
      @(negedge clk);
      wb_valid = 1'b0;
      #1;
      check("xzr_count", 64'(count), 64'd0);
      check("xzr_rw", 64'(RegWrite), 64'd0);

      // forwarding priority
      drain_en = 1'b0;
      ReadRegister1 = 5'd7;
      ReadRegister2 = 5'd8;
      RfData1 = 64'h99;
      RfData2 = 64'h77;
      @(negedge clk);
      wb_valid = 1'b1;
      wb_reg = 5'd7;
      wb_data = 64'h10;
      @(negedge clk);
      wb_data = 64'h20;
      #1;
      check("fw_older", ReadData1, 64'h10);
      @(negedge clk);
      wb_valid = 1'b0;
      #1;
      check("fw_newest", ReadData1, 64'h20);
      check("fw_miss", ReadData2, 64'h77);
      drain_en = 1'b1;
      #1;
      check("fw_head_wr", 64'(WriteData), 64'h10);
      check("fw_head_rd", ReadData1, 64'h20);
      step();
      check("fw_last", ReadData1, 64'h20);
      step();
      check("fw_drained", ReadData1, 64'h99);

      // incoming request visibility on read ports
      drain_en = 1'b0;
      @(negedge clk);
      ReadRegister1 = 5'd9;
      wb_valid = 1'b1;
      wb_reg = 5'd9;
      wb_data = 64'hABC;
      #1;
`ifdef REGFILE_WBQ_ENQ_BYPASS_EN
      check("byp_same", ReadData1, 64'hABC);
`else
      check("byp_same", ReadData1, 64'h99);
`endif
      @(negedge clk);
      wb_valid = 1'b0;
      #1;
      check("byp_next", ReadData1, 64'hABC);
      drain_en = 1'b1;
      step();
      check("byp_drain", 64'(empty), 64'd1);

      // streaming with wrap
      ReadRegister1 = '0;
      ReadRegister2 = '0;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         wb_valid = (i <= 10);
         wb_reg = 5'(i);
         wb_data = 64'(16'h100 + i);
         #1;
         check("st_count", 64'(count), (i == 1) ? 64'd0 : 64'd1);
         if (i >= 2) begin
            check("st_rw", 64'(RegWrite), 64'd1);
            check("st_wreg", 64'(WriteRegister), 64'(i - 1));
            check("st_wdata", WriteData, 64'(16'h100 + i - 1));
         end
      end
      wb_valid = 1'b0;
      step();
      check("st_empty", 64'(empty), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Write-side companion to the 32x64 register file.
- Buffers write-back requests from the execute/memory stages in a small FIFO.
- Drains one entry per cycle into the register file's single write port (RegWrite/WriteRegister/WriteData).
- Forwards still-pending write data onto the two read ports, so readers never see stale register contents while writes wait in the queue.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- DW, 64, data width.
- AW, 5, register address width; register 31 is XZR.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wb_valid  input  1  producer presents a write-back request.
- wb_ready  output  1  queue can accept this cycle; equals not full.
- wb_reg  input  AW  destination register.
- wb_data  input  DW  write-back value.
- drain_en  input  1  write port available this cycle.
- RegWrite  output  1  write strobe to register file.
- WriteRegister  output  AW  register file write address.
- WriteData  output  DW  register file write data.
- ReadRegister1  input  AW  read address, port 1.
- ReadRegister2  input  AW  read address, port 2.
- RfData1  input  DW  raw register file read data, port 1.
- RfData2  input  DW  raw register file read data, port 2.
- ReadData1  output  DW  forwarded read data, port 1.
- ReadData2  output  DW  forwarded read data, port 2.
- count  output  clog2(DEPTH+1)  occupied entries.
- empty  output  1  count == 0.

Behaviour:
- Reset (asynchronous assert, any cycle including mid-drain):
  - All entries invalid; head/tail pointers 0; count 0; empty 1; wb_ready 1.
  - RegWrite 0; WriteRegister 0; WriteData 0.
- Enqueue occurs when wb_valid && wb_ready at the clock edge.
  - If wb_reg == 31, the request is accepted (handshake completes) but not stored; count is unchanged.
- Dequeue occurs when RegWrite is 1 at the edge.
  - RegWrite = !empty && drain_en.
  - WriteRegister/WriteData = head entry fields when not empty, else 0.
- Latency:
  - An accepted request appears on the write port the cycle after acceptance, at the earliest.
  - No same-cycle pass-through from wb_* to the write port.
- Full: wb_ready = 0 when count == DEPTH, even if a dequeue occurs in that cycle (no bypass of full).
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count is unchanged; pointers both advance.
- Ordering: strict FIFO. Multiple pending writes to the same register are all issued, oldest first.
- Pointers wrap modulo DEPTH.
- Forwarding, per read port p:
  - If ReadRegister_p == 31, ReadData_p = 0.
  - Else, if any valid entry matches ReadRegister_p, ReadData_p = data of the newest matching entry. This includes the head entry being written this cycle, because the register file updates only at the edge.
  - Else ReadData_p = RfData_p.
  - Forwarding is purely combinational from state and read addresses.
- drain_en low holds the head entry. The queue may still fill.

Optional Feature:
- Macro: REGFILE_WBQ_ENQ_BYPASS_EN
- Defined:
  - A request being accepted this cycle (wb_valid && wb_ready, wb_reg != 31) also forwards wb_data to any read port whose address matches.
  - This bypass has priority over all queued entries.
- Undefined:
  - The incoming request is visible to the read ports only from the cycle after acceptance.
  - Same-cycle readers get queue or register file data.

Decomposition:
- Shared package regfile_pkg:
  - REG_AW = 5, REG_DW = 64, XZR_IDX = 31.
  - typedef wbq_entry_t: struct {logic valid; logic [4:0] reg_idx; logic [63:0] data}.
- One natural sub-module: wbq_forward_match.
  - Combinational newest-match priority search over entries for one read port.
  - Instantiated twice, once per read port.

Test Plan:
- Reset mid-drain: enqueue X3=0xAA, X4=0xBB, then assert reset during the X3 write cycle -> RegWrite=0, count=0, empty=1, wb_ready=1 while reset is low; X4 is never written.
- Basic latency, drain_en=1: enqueue X5=0x1234 at cycle 0 -> RegWrite=1, WriteRegister=5, WriteData=0x1234 at cycle 1; empty=1 at cycle 2.
- Fill/full, drain_en=0: enqueue X1..X4 -> count=4, wb_ready=0; a 5th wb_valid is not accepted. Raise drain_en -> writes X1,X2,X3,X4 on consecutive cycles and wb_ready=1 from the cycle after the first drain.
- XZR: enqueue X31=0xFFFF -> count stays 0, no RegWrite. ReadRegister1=31 with RfData1=0x55 -> ReadData1=0.
- Forwarding priority, drain_en=0: enqueue X7=0x10 then X7=0x20, RfData1=0x99, ReadRegister1=7 -> ReadData1=0x20. ReadRegister2=8 -> ReadData2=RfData2. After both drain -> ReadData1=RfData1.
- Wrap and simultaneous traffic: DEPTH=4, stream 10 requests X1..X10 (data = 0x100 + reg index) with drain_en=1 and wb_valid held high -> write port sees all 10 in order, count never exceeds 1, pointers wrap twice.
